// File: rtl/apb_master_nslv_pkg.sv
// Shared types and helpers for the N-slave APB4 master.
//  state_e     : FSM state encoding (IDLE/SETUP/ACCESS/DERR)
//  sel_bits()  : number of top address bits used as slave index
//  strb_en()   : APB4 strobe rule, strobes only carry meaning on writes
package apb_master_nslv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DERR   = 2'd3
   } state_e;

   // At least one select bit, even for a single slave.
   function automatic int unsigned sel_bits(input int unsigned num_slv);
      return (num_slv <= 1) ? 1 : $clog2(num_slv);
   endfunction

   // Reads drive all-zero strobes on the bus.
   function automatic logic strb_en(input logic is_write);
      return is_write;
   endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// Shared APB4 bus between one master and NUM_SLV slaves.
//  master modport : drives psel/penable/pwrite/paddr/pwdata/pstrb,
//                   receives prdata/pready/pslverr (slave i at [i*WIDTH +: WIDTH] / bit i)
//  slave modport  : mirror image
interface apb_master_nslv_if #(
   parameter int unsigned ADD_WIDTH = 9,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_SLV   = 2
);
   localparam int unsigned STRB_W = WIDTH / 8;

   logic [NUM_SLV-1:0]       psel;
   logic                     penable;
   logic                     pwrite;
   logic [ADD_WIDTH-1:0]     paddr;
   logic [WIDTH-1:0]         pwdata;
   logic [STRB_W-1:0]        pstrb;
   logic [NUM_SLV*WIDTH-1:0] prdata;
   logic [NUM_SLV-1:0]       pready;
   logic [NUM_SLV-1:0]       pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_master_nslv_addr_decode.sv
// Combinational slave decoder: address select field -> one-hot select + decode error.
//  addr_hi_i     : top SEL_BITS of the request address
//  sel_c_o       : one-hot slave select, all zero on decode error
//  decode_err_c_o: select field names a slave that does not exist
module apb_master_nslv_addr_decode
   import apb_master_nslv_pkg::*;
#(
   parameter int unsigned NUM_SLV = 2
) (
   input  logic [sel_bits(NUM_SLV)-1:0] addr_hi_i,
   output logic [NUM_SLV-1:0]           sel_c_o,
   output logic                         decode_err_c_o
);
   localparam int unsigned SEL_BITS = sel_bits(NUM_SLV);

   always_comb begin
      sel_c_o        = '0;
      decode_err_c_o = (32'(addr_hi_i) >= NUM_SLV);
      for (int i = 0; i < NUM_SLV; i++) begin
         if (addr_hi_i == SEL_BITS'(i)) sel_c_o[i] = 1'b1;
      end
   end
endmodule

// File: rtl/apb_master_nslv.sv
// APB4 master driving one shared bus to NUM_SLV slaves.
//  pclk/preset      : clock, synchronous active-high reset
//  transfer/req_ready: request handshake (req_ready is combinational)
//  Req_*            : request direction, strobes, address, write data
//  rsp_valid/rsp_err/Req_rdata : one-cycle response pulse, error flag, read data
//  apb              : APB bus (master modport)
module apb_master_nslv
   import apb_master_nslv_pkg::*;
#(
   parameter int unsigned ADD_WIDTH = 9,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_SLV   = 2,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 transfer,
   output logic                 req_ready,
   input  logic                 Req_read_write,
   input  logic [WIDTH/8-1:0]   Req_pstrb,
   input  logic [ADD_WIDTH-1:0] Req_addr,
   input  logic [WIDTH-1:0]     Req_wdata,
   output logic                 rsp_valid,
   output logic [WIDTH-1:0]     Req_rdata,
   output logic                 rsp_err,
   apb_master_nslv_if.master    apb
);
   localparam int unsigned STRB_W   = WIDTH / 8;
   localparam int unsigned SEL_BITS = sel_bits(NUM_SLV);
   localparam int unsigned TCNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [NUM_SLV-1:0]   psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 pwrite_q, pwrite_d;
   logic [ADD_WIDTH-1:0] paddr_q, paddr_d;
   logic [WIDTH-1:0]     pwdata_q, pwdata_d;
   logic [STRB_W-1:0]    pstrb_q, pstrb_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0]     rdata_q, rdata_d;
   logic [TCNT_W-1:0]    tcnt_q, tcnt_d;

   logic [NUM_SLV-1:0]   dec_sel_c;
   logic                 dec_err_c;
   logic                 pready_sel_c;
   logic                 pslverr_sel_c;
   logic [WIDTH-1:0]     prdata_sel_c;
   logic                 timeout_c;

   // Slave select decode of the incoming request.
   apb_master_nslv_addr_decode #(
      .NUM_SLV (NUM_SLV)
   ) u_decode (
      .addr_hi_i      (Req_addr[ADD_WIDTH-1 -: SEL_BITS]),
      .sel_c_o        (dec_sel_c),
      .decode_err_c_o (dec_err_c)
   );

   // Response mux: only the currently selected slave is observed.
   always_comb begin
      pready_sel_c  = |(apb.pready & psel_q);
      pslverr_sel_c = |(apb.pslverr & psel_q);
      prdata_sel_c  = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (psel_q[i]) prdata_sel_c = prdata_sel_c | apb.prdata[i*WIDTH +: WIDTH];
      end
   end

   // Abort on the last permitted ACCESS cycle without pready; pready takes priority.
   always_comb begin
      timeout_c = 1'b0;
      if (TIMEOUT != 0) begin
         timeout_c = (state_q == ACCESS) && !pready_sel_c && (tcnt_q == TCNT_LAST);
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      logic accept;
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rdata_d     = rdata_q;
      tcnt_d      = '0;
      req_ready   = 1'b0;
      accept      = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            accept    = transfer;
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready_sel_c || timeout_c) begin
               req_ready   = 1'b1;
               rsp_valid_d = 1'b1;
               psel_d      = '0;
               penable_d   = 1'b0;
               state_d     = IDLE;
               if (pready_sel_c) begin
                  rsp_err_d = pslverr_sel_c;
                  if (!pwrite_q) rdata_d = prdata_sel_c;
               end else begin
                  rsp_err_d = 1'b1;
                  rdata_d   = '0;
               end
               accept = transfer;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         DERR: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = '0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Request latch, shared by IDLE and back-to-back acceptance in ACCESS.
      if (accept) begin
         pwrite_d  = Req_read_write;
         paddr_d   = Req_addr;
         pwdata_d  = Req_wdata;
         pstrb_d   = Req_pstrb & {STRB_W{strb_en(Req_read_write)}};
         penable_d = 1'b0;
         if (dec_err_c) begin
            psel_d  = '0;
            state_d = DERR;
         end else begin
            psel_d  = dec_sel_c;
            state_d = SETUP;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q     <= IDLE;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
         tcnt_q      <= tcnt_d;
      end
   end

   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;
   assign apb.pstrb   = pstrb_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign Req_rdata   = rdata_q;

endmodule
